// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the target-shooting game controller.
//   - game_state_e : FSM state encodings (IDLE=0, WAIT=1, GAME=2, SCORE=3)
//   - default start/stop button geometry in pixels
//   - in_rect()    : half-open rectangle hit test on 12-bit cursor coordinates
package game_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWait  = 2'd1,
        StGame  = 2'd2,
        StScore = 2'd3
    } game_state_e;

    localparam int unsigned CoordW = 12;
    // One extra bit so X+W style bounds near the top of the screen cannot wrap.
    localparam int unsigned CmpW   = CoordW + 1;

    localparam int unsigned StartXDef = 360;
    localparam int unsigned StartYDef = 192;
    localparam int unsigned StartWDef = 80;
    localparam int unsigned StartHDef = 32;

    localparam int unsigned StopXDef  = 700;
    localparam int unsigned StopYDef  = 10;
    localparam int unsigned StopWDef  = 80;
    localparam int unsigned StopHDef  = 32;

    // True when (x, y) lies in [rx, rx+rw) x [ry, ry+rh).
    function automatic logic in_rect(input logic [CoordW-1:0] x,
                                     input logic [CoordW-1:0] y,
                                     input int unsigned       rx,
                                     input int unsigned       ry,
                                     input int unsigned       rw,
                                     input int unsigned       rh);
        logic [CmpW-1:0] xe, ye, x_lo, x_hi, y_lo, y_hi;
        xe   = {1'b0, x};
        ye   = {1'b0, y};
        x_lo = CmpW'(rx);
        x_hi = CmpW'(rx + rw);
        y_lo = CmpW'(ry);
        y_hi = CmpW'(ry + rh);
        return (xe >= x_lo) && (xe < x_hi) && (ye >= y_lo) && (ye < y_hi);
    endfunction

endpackage

// File: rtl/game_fsm_tick_gen.sv
// tick_gen: one-second prescaler for the game controller.
//   pclk : clock, rising edge
//   rst  : synchronous active-low reset
//   en   : count while high; counter held at 0 while low
//   clr  : force the counter back to 0 on the next edge
//   tick : high during the last cycle of each CLK_HZ-cycle period (counter at CLK_HZ-1)
// tick is decoded from the counter register only, so the owner can register it
// alongside the state update it causes.
module tick_gen #(
    parameter int unsigned CLK_HZ = 40_000_000
) (
    input  logic pclk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned     CntW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_HZ - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == CntMax);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clr || !en || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_fsm.sv
// game_fsm: round controller for a mouse-driven target game.
//   pclk        : clock, rising edge
//   rst         : synchronous active-low reset
//   mouse_xpos  : cursor X (12b, pclk domain)
//   mouse_ypos  : cursor Y (12b, pclk domain)
//   mouse_left  : left button level; a rising edge is a click
//   uart_start  : remote player ready level
//   hit         : one-cycle target-hit pulse
//   state       : IDLE=0, WAIT=1, GAME=2, SCORE=3
//   time_left   : seconds remaining in GAME or SCORE, 0 otherwise
//   score       : saturating hit counter for the current round
//   game_active : high iff state==GAME
//   sec_tick    : one-cycle pulse for each elapsed second in GAME/SCORE
// Every output comes straight from a register.
module game_fsm
    import game_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 40_000_000,
    parameter int unsigned GAME_SEC = 60,
    parameter int unsigned HOLD_SEC = 5,
    parameter int unsigned SCORE_W  = 8,
    parameter int unsigned START_X  = StartXDef,
    parameter int unsigned START_Y  = StartYDef,
    parameter int unsigned START_W  = StartWDef,
    parameter int unsigned START_H  = StartHDef,
    parameter int unsigned STOP_X   = StopXDef,
    parameter int unsigned STOP_Y   = StopYDef,
    parameter int unsigned STOP_W   = StopWDef,
    parameter int unsigned STOP_H   = StopHDef,
    localparam int unsigned TIME_W  =
        $clog2(((GAME_SEC > HOLD_SEC) ? GAME_SEC : HOLD_SEC) + 1)
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic [11:0]        mouse_xpos,
    input  logic [11:0]        mouse_ypos,
    input  logic               mouse_left,
    input  logic               uart_start,
    input  logic               hit,
    output logic [1:0]         state,
    output logic [TIME_W-1:0]  time_left,
    output logic [SCORE_W-1:0] score,
    output logic               game_active,
    output logic               sec_tick
);

    game_state_e        state_q, state_d;
    logic [TIME_W-1:0]  time_q, time_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               active_q;
    logic               sec_tick_q;
    logic               mouse_left_q;

    logic click, in_start, in_stop;
    logic tick, tick_en, tick_clr;

    assign click    = mouse_left && !mouse_left_q;
    assign in_start = in_rect(mouse_xpos, mouse_ypos, START_X, START_Y, START_W, START_H);
    assign in_stop  = in_rect(mouse_xpos, mouse_ypos, STOP_X, STOP_Y, STOP_W, STOP_H);

    // Prescaler runs only in the timed states and restarts on every state change,
    // so each GAME/SCORE period begins a full second before its first tick.
    assign tick_en  = (state_q == StGame) || (state_q == StScore);
    assign tick_clr = (state_d != state_q);

    tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .pclk (pclk),
        .rst  (rst),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        score_d = score_q;

        // Counted even on the final tick or the exit edge of GAME.
        if ((state_q == StGame) && hit && (score_q != '1)) begin
            score_d = score_q + SCORE_W'(1);
        end

        case (state_q)
            StIdle: begin
                time_d = '0;
                if (click && in_start) begin
                    state_d = StWait;
                    score_d = '0;
                end
            end
            StWait: begin
                time_d = '0;
                if (click && in_stop) begin
                    state_d = StIdle;
                end else if (uart_start) begin
                    state_d = StGame;
                    time_d  = TIME_W'(GAME_SEC);
                end
            end
            StGame: begin
                // Stop beats a coincident final tick.
                if (click && in_stop) begin
                    state_d = StIdle;
                    time_d  = '0;
                end else if (tick) begin
                    if (time_q == TIME_W'(1)) begin
                        state_d = StScore;
                        time_d  = TIME_W'(HOLD_SEC);
                    end else begin
                        time_d = time_q - TIME_W'(1);
                    end
                end
            end
            StScore: begin
                if (click && in_start) begin
                    state_d = StWait;
                    time_d  = '0;
                    score_d = '0;
                end else if (tick) begin
                    if (time_q == TIME_W'(1)) begin
                        state_d = StIdle;
                        time_d  = '0;
                    end else begin
                        time_d = time_q - TIME_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                time_d  = '0;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            state_q      <= StIdle;
            time_q       <= '0;
            score_q      <= '0;
            active_q     <= 1'b0;
            sec_tick_q   <= 1'b0;
            mouse_left_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            time_q       <= time_d;
            score_q      <= score_d;
            active_q     <= (state_d == StGame);
            sec_tick_q   <= tick;
            mouse_left_q <= mouse_left;
        end
    end

    assign state       = state_q;
    assign time_left   = time_q;
    assign score       = score_q;
    assign game_active = active_q;
    assign sec_tick    = sec_tick_q;

endmodule

// File: tb/tb_game_fsm.sv
module tb_game_fsm;

    localparam int CLK_HZ   = 10;
    localparam int GAME_SEC = 3;
    localparam int HOLD_SEC = 2;
    localparam int SCORE_W  = 4;
    localparam int TIME_W   = 2;
    localparam int SCORE_MAX = 15;

    // Button geometry (DUT uses its defaults)
    localparam int SX = 360, SY = 192, SW = 80, SH = 32;
    localparam int PX = 700, PY = 10,  PW = 80, PH = 32;

    logic               pclk = 1'b0;
    logic               rst = 1'b0;
    logic [11:0]        mouse_xpos = '0;
    logic [11:0]        mouse_ypos = '0;
    logic               mouse_left = 1'b0;
    logic               uart_start = 1'b0;
    logic               hit = 1'b0;
    logic [1:0]         state;
    logic [TIME_W-1:0]  time_left;
    logic [SCORE_W-1:0] score;
    logic               game_active;
    logic               sec_tick;

    game_fsm #(
        .CLK_HZ   (CLK_HZ),
        .GAME_SEC (GAME_SEC),
        .HOLD_SEC (HOLD_SEC),
        .SCORE_W  (SCORE_W)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .mouse_xpos  (mouse_xpos),
        .mouse_ypos  (mouse_ypos),
        .mouse_left  (mouse_left),
        .uart_start  (uart_start),
        .hit         (hit),
        .state       (state),
        .time_left   (time_left),
        .score       (score),
        .game_active (game_active),
        .sec_tick    (sec_tick)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int st;
        int tl;
        int sc;
        int ga;
        int tk;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model: round phase, seconds remaining, cycles spent in the
    // current timed phase, score, and the previous button level.
    int m_mode = 0;   // 0 idle, 1 wait, 2 game, 3 score
    int m_secs = 0;
    int m_pc   = 0;
    int m_score = 0;
    int m_prev = 0;
    int m_tick = 0;

    function automatic bit inside_box(int x, int y, int bx, int by, int bw, int bh);
        return (x >= bx) && (x < bx + bw) && (y >= by) && (y < by + bh);
    endfunction

    function automatic bit final_tick_next();
        return (m_mode == 2) && (m_secs == 1) && ((m_pc % CLK_HZ) == CLK_HZ - 1);
    endfunction

    task automatic model(int ml, int x, int y, int us, int h, int r);
        bit clk_ev, ins, inp, timed, tk;
        if (r == 0) begin
            m_mode = 0; m_secs = 0; m_pc = 0; m_score = 0; m_prev = 0; m_tick = 0;
            return;
        end
        clk_ev = (ml != 0) && (m_prev == 0);
        m_prev = ml;
        ins    = inside_box(x, y, SX, SY, SW, SH);
        inp    = inside_box(x, y, PX, PY, PW, PH);
        timed  = (m_mode == 2) || (m_mode == 3);
        // A second has elapsed once CLK_HZ cycles have been spent in the phase.
        tk     = timed && ((m_pc % CLK_HZ) == CLK_HZ - 1);
        m_pc++;
        if (h != 0 && m_mode == 2 && m_score < SCORE_MAX) m_score++;
        case (m_mode)
            0: if (clk_ev && ins) begin m_mode = 1; m_score = 0; end
            1: begin
                if (clk_ev && inp) m_mode = 0;
                else if (us != 0) begin m_mode = 2; m_secs = GAME_SEC; m_pc = 0; end
            end
            2: begin
                if (clk_ev && inp) begin m_mode = 0; m_secs = 0; end
                else if (tk) begin
                    if (m_secs == 1) begin m_mode = 3; m_secs = HOLD_SEC; m_pc = 0; end
                    else m_secs--;
                end
            end
            default: begin
                if (clk_ev && ins) begin m_mode = 1; m_secs = 0; m_score = 0; end
                else if (tk) begin
                    if (m_secs == 1) begin m_mode = 0; m_secs = 0; end
                    else m_secs--;
                end
            end
        endcase
        m_tick = tk;
    endtask

    task automatic step(int ml, int x, int y, int us, int h, int r);
        exp_t e;
        @(negedge pclk);
        mouse_left = ml[0];
        mouse_xpos = x[11:0];
        mouse_ypos = y[11:0];
        uart_start = us[0];
        hit        = h[0];
        rst        = r[0];
        model(ml, x, y, us, h, r);
        e.st = m_mode;
        e.tl = m_secs;
        e.sc = m_score;
        e.ga = (m_mode == 2) ? 1 : 0;
        e.tk = m_tick;
        exp_q.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic click_at(int x, int y);
        step(1, x, y, 0, 0, 1);
        step(0, x, y, 0, 0, 1);
    endtask

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL cycle %0d %s: got %0d, expected %0d", cyc, nm, got, want);
        end
    endtask

    // Monitor: every cycle the DUT presents a new registered output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge pclk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("state", 32'(state), e.st);
                chk("time_left", 32'(time_left), e.tl);
                chk("score", 32'(score), e.sc);
                chk("game_active", 32'(game_active), e.ga);
                chk("sec_tick", 32'(sec_tick), e.tk);
            end
        end
    end

    task automatic run_until_mode(int mode, int limit, string nm);
        int g = 0;
        while (m_mode != mode && g < limit) begin
            idle(1);
            g++;
        end
        n_checks++;
        if (m_mode != mode) begin
            n_fail++;
            $display("FAIL %s: phase %0d not reached, expected %0d", nm, m_mode, mode);
        end
    endtask

    int pts_x[12] = '{370, 360, 439, 440, 359, 400, 710, 700, 779, 780, 700, 0};
    int pts_y[12] = '{200, 192, 223, 200, 200, 224, 20,  10,  41,  20,  42,  0};

    initial begin
        int g;
        int ml, x, y, k;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        idle(3);

        // Boundary clicks just outside the start button keep IDLE.
        click_at(440, 200);
        click_at(359, 200);
        click_at(400, 224);

        // Held button across IDLE->WAIT and onto the stop button: one event only.
        for (int i = 0; i < 4; i++) step(1, 370, 200, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 710, 20, 0, 0, 1);
        step(0, 710, 20, 0, 0, 1);

        // Start, saturate score, run GAME to SCORE (hits ignored) and back to IDLE.
        step(0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 1, 1);
        run_until_mode(3, 40, "game_to_score");
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 1);
        run_until_mode(0, 40, "score_to_idle");

        // Stop click on the exact cycle of the final GAME tick.
        click_at(370, 200);
        step(0, 0, 0, 1, 0, 1);
        g = 0;
        while (!final_tick_next() && g < 100) begin
            idle(1);
            g++;
        end
        n_checks++;
        if (!final_tick_next()) begin
            n_fail++;
            $display("FAIL final_tick_align: not reached after %0d cycles, expected <100", g);
        end
        step(1, 710, 20, 0, 0, 1);
        step(0, 710, 20, 0, 0, 1);
        idle(3);

        // SCORE -> WAIT via start click, then stop from WAIT.
        click_at(370, 200);
        step(0, 0, 0, 1, 1, 1);
        run_until_mode(3, 40, "reach_score");
        idle(4);
        click_at(439, 223);
        click_at(779, 41);

        // Reset mid-GAME with a non-zero score.
        click_at(370, 200);
        step(0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 1);
        idle(3);
        step(0, 0, 0, 0, 1, 0);
        idle(3);

        // Randomised traffic.
        ml = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) ml = 1 - ml;
            k = $urandom_range(0, 12);
            if (k < 11) begin
                x = pts_x[k];
                y = pts_y[k];
            end else begin
                x = $urandom_range(0, 4095);
                y = $urandom_range(0, 4095);
            end
            step(ml, x, y, ($urandom_range(0, 3) == 0) ? 1 : 0,
                 ($urandom_range(0, 2) == 0) ? 1 : 0,
                 ($urandom_range(0, 199) == 0) ? 0 : 1);
        end

        idle(1);
        repeat (3) @(posedge pclk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
